// File: rtl/mem_resp_pkg.sv
// Shared definitions for the data memory responder: FSM states and the
// default location of the memory window in the byte address space.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0010_0000;

endpackage

// File: rtl/be_word_ram.sv
// DEPTH x 32 word storage with byte-lane write enables on the rising edge
// and a combinational read port sharing the same word address.
module be_word_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [3:0]               be,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    // Write only the byte lanes whose enable is set; other lanes keep their value.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder: grants one request at a time, waits a
// fixed latency, then returns a one-cycle response with read data or error.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        error_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    state_t          state;
    state_t          next_state;
    logic [3:0]      cnt;
    logic [31:0]     addr_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;

    logic            in_range;
    logic            aligned;
    logic            acc_ok;
    logic [AW-1:0]   word_idx;
    logic            ram_we;
    logic [31:0]     ram_rdata;

    // The window limit is compared in 33 bits so a window ending at the top
    // of the address space does not wrap to zero.
    assign in_range = ({1'b0, addr_q} >= BASE_EXT) && ({1'b0, addr_q} < LIMIT);
    assign aligned  = (addr_q[1:0] == 2'b00);
    assign acc_ok   = in_range && aligned;
    assign word_idx = AW'((addr_q - BASE_ADDR) >> 2);

    // A write lands in the response cycle, and never when reset cuts it short.
    assign ram_we = (state == RESP) && we_q && acc_ok && !reset;

    be_word_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (word_idx),
        .be    (be_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // State, latency counter and the captured request; capture happens on grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
        end else begin
            state <= next_state;
            if (gnt_o) begin
                cnt     <= 4'(LATENCY - 1);
                addr_q  <= addr_i;
                we_q    <= we_i;
                be_q    <= be_i;
                wdata_q <= wdata_i;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Next-state and outputs; everything is held low while reset is asserted.
    always_comb begin
        next_state = state;
        gnt_o      = 1'b0;
        rvalid_o   = 1'b0;
        rdata_o    = 32'h0;
        error_o    = 1'b0;
        case (state)
            IDLE: begin
                if (req_i && !reset) begin
                    gnt_o      = 1'b1;
                    next_state = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
                if (!reset) begin
                    rvalid_o = 1'b1;
                    error_o  = !acc_ok;
                    rdata_o  = (!we_q && acc_ok) ? ram_rdata : 32'h0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (latency 2, 1 and 4) sharing clock
// and reset, checked against a simple word-array model of the memory window.
module tb_data_mem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic        gnt   [3];
    logic        rvalid[3];
    logic [31:0] rdata [3];
    logic        error [3];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl [DEPTH];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut_l2 (
        .clk(clk), .reset(reset), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .error_o(error[0]));

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut_l1 (
        .clk(clk), .reset(reset), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .error_o(error[1]));

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(4), .BASE_ADDR(BASE)) dut_l4 (
        .clk(clk), .reset(reset), .req_i(req[2]), .addr_i(addr[2]), .we_i(we[2]),
        .be_i(be[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
        .rdata_o(rdata[2]), .error_o(error[2]));

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    // Issue one request on instance k and collect its response and latency.
    task automatic run_txn(input int k, input logic [31:0] a, input logic w,
                           input logic [3:0] b, input logic [31:0] d,
                           output logic [31:0] rd, output logic er, output int lat);
        bit got;
        got = 0;
        lat = -1;
        rd  = 32'h0;
        er  = 1'b0;
        @(negedge clk);
        req[k] = 1'b1; addr[k] = a; we[k] = w; be[k] = b; wdata[k] = d;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (gnt[k] === 1'b1) got = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("[TB] FAIL grant_timeout dut=%0d addr=%h: no grant seen, required one", k, a);
            req[k] = 1'b0;
            return;
        end
        @(negedge clk);
        req[k] = 1'b0; we[k] = 1'b0; wdata[k] = 32'h0;
        for (int n = 1; n <= 20; n++) begin
            if (rvalid[k] === 1'b1) begin
                lat = n; rd = rdata[k]; er = error[k];
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if (rvalid[k] !== 1'b0 || rdata[k] !== 32'h0 || error[k] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL post_resp_quiet dut=%0d rvalid=%b rdata=%h error=%b, required 0/0/0",
                     k, rvalid[k], rdata[k], error[k]);
        end
    endtask

    task automatic check_txn(input string name, input int k, input logic [31:0] rd,
                             input logic er, input int lat,
                             input logic [31:0] exp_rd, input logic exp_er);
        n_cmp++;
        if (lat !== lat_of(k) || rd !== exp_rd || er !== exp_er) begin
            n_bad++;
            $display("[TB] FAIL %s dut=%0d got lat=%0d rdata=%h error=%b, required lat=%0d rdata=%h error=%b",
                     name, k, lat, rd, er, lat_of(k), exp_rd, exp_er);
        end
    endtask

    task automatic test_reset();
        logic bad;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b1; addr[k] = BASE; we[k] = 1'b0; be[k] = 4'hF; wdata[k] = 32'h0;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (gnt[k] !== 1'b0 || rvalid[k] !== 1'b0 || rdata[k] !== 32'h0 || error[k] !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL reset_outputs dut=%0d gnt=%b rvalid=%b rdata=%h error=%b, required all 0",
                             k, gnt[k], rvalid[k], rdata[k], error[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                bad = (gnt[k] !== 1'b0) || (rvalid[k] !== 1'b0);
                n_cmp++;
                if (bad) begin
                    n_bad++;
                    $display("[TB] FAIL idle_quiet dut=%0d cycle=%0d gnt=%b rvalid=%b, required 0/0",
                             k, c, gnt[k], rvalid[k]);
                end
            end
        end
    endtask

    task automatic test_full_word();
        logic [31:0] rd; logic er; int lat;
        run_txn(0, BASE + 32'd8, 1'b1, 4'hF, 32'hDEADBEEF, rd, er, lat);
        check_txn("full_write", 0, rd, er, lat, 32'h0, 1'b0);
        run_txn(0, BASE + 32'd8, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check_txn("full_read", 0, rd, er, lat, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_partial_write();
        logic [31:0] rd; logic er; int lat;
        run_txn(0, BASE + 32'd8, 1'b1, 4'b0101, 32'h11223344, rd, er, lat);
        check_txn("partial_write", 0, rd, er, lat, 32'h0, 1'b0);
        run_txn(0, BASE + 32'd8, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check_txn("partial_read", 0, rd, er, lat, 32'hDE22BE44, 1'b0);
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        logic [31:0] last;
        last = BASE + 32'(4 * DEPTH) - 32'd4;
        run_txn(0, last, 1'b1, 4'hF, 32'hA5A55A5A, rd, er, lat);
        check_txn("last_word_write", 0, rd, er, lat, 32'h0, 1'b0);
        run_txn(0, BASE + 32'd2, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check_txn("misaligned_read", 0, rd, er, lat, 32'h0, 1'b1);
        run_txn(0, BASE + 32'(4 * DEPTH), 1'b1, 4'hF, 32'h12345678, rd, er, lat);
        check_txn("past_end_write", 0, rd, er, lat, 32'h0, 1'b1);
        run_txn(0, 32'hFFFF_FFFC, 1'b1, 4'hF, 32'h87654321, rd, er, lat);
        check_txn("top_of_space_write", 0, rd, er, lat, 32'h0, 1'b1);
        run_txn(0, last, 1'b1, 4'h0, 32'hFFFFFFFF, rd, er, lat);
        check_txn("zero_be_write", 0, rd, er, lat, 32'h0, 1'b0);
        run_txn(0, last, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check_txn("last_word_unchanged", 0, rd, er, lat, 32'hA5A55A5A, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        int g[$]; int r[$]; logic [31:0] rds[$];
        run_txn(1, BASE + 32'd8, 1'b1, 4'hF, 32'h0BADF00D, rd, er, lat);
        check_txn("b2b_setup_write", 1, rd, er, lat, 32'h0, 1'b0);
        @(negedge clk);
        req[1] = 1'b1; addr[1] = BASE + 32'd8; we[1] = 1'b0; be[1] = 4'hF;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (gnt[1] === 1'b1) g.push_back(c);
            if (rvalid[1] === 1'b1) begin
                r.push_back(c);
                rds.push_back(rdata[1]);
            end
            @(negedge clk);
            if (g.size() >= 3) req[1] = 1'b0;
        end
        n_cmp++;
        if (g.size() != 3 || r.size() != 3) begin
            n_bad++;
            $display("[TB] FAIL b2b_counts got grants=%0d rvalids=%0d, required 3/3", g.size(), r.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (g[i] != 2 * i || r[i] != 2 * i + 1 || rds[i] !== 32'h0BADF00D) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_slot%0d got gnt@%0d rvalid@%0d rdata=%h, required gnt@%0d rvalid@%0d rdata=0badf00d",
                             i, g[i], r[i], rds[i], 2 * i, 2 * i + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int seen;
        run_txn(2, BASE, 1'b1, 4'hF, 32'hCAFEF00D, rd, er, lat);
        check_txn("mid_setup_write", 2, rd, er, lat, 32'h0, 1'b0);
        @(negedge clk);
        req[2] = 1'b1; addr[2] = BASE; we[2] = 1'b1; be[2] = 4'hF; wdata[2] = 32'h12345678;
        #1;
        n_cmp++;
        if (gnt[2] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL mid_grant got gnt=%b, required 1", gnt[2]);
        end
        @(negedge clk);
        req[2] = 1'b0;
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (rvalid[2] !== 1'b0 || gnt[2] !== 1'b0) seen++;
            @(negedge clk);
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (rvalid[2] !== 1'b0) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("[TB] FAIL mid_no_rvalid got %0d active cycles, required 0", seen);
        end
        run_txn(2, BASE, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check_txn("mid_old_value", 2, rd, er, lat, 32'hCAFEF00D, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat;
        logic [31:0] a; logic w; logic [3:0] b; logic [31:0] d;
        logic [31:0] exp_rd; logic exp_er; bit ok; longint ua; int idx; int sel;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            run_txn(0, BASE + 32'(4 * i), 1'b1, 4'hF, d, rd, er, lat);
            mdl[i] = d;
            check_txn("rand_init", 0, rd, er, lat, 32'h0, 1'b0);
        end
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                6:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                7:       a = BASE - 32'd4;
                8:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
                9:       a = 32'hFFFF_FFFC;
                default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            w = 1'($urandom_range(0, 1));
            b = 4'($urandom_range(0, 15));
            d = $urandom;
            ua = longint'(a);
            ok = (a % 4 == 0) && (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEPTH);
            idx = ok ? int'((ua - longint'(BASE)) / 4) : 0;
            exp_er = !ok;
            exp_rd = (!w && ok) ? mdl[idx] : 32'h0;
            run_txn(0, a, w, b, d, rd, er, lat);
            if (w && ok) begin
                for (int n = 0; n < 4; n++)
                    if (b[n]) mdl[idx][8*n +: 8] = d[8*n +: 8];
            end
            check_txn("rand_txn", 0, rd, er, lat, exp_rd, exp_er);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_full_word();
        test_partial_write();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024; number of 32-bit words, power of two, at least 4.
REQ-002 Parameter LATENCY, default 2; cycles from grant to rvalid, range 1..8.
REQ-003 Parameter BASE_ADDR, default 32'h0010_0000; byte address of word 0, aligned to DEPTH*4.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_i  input  1  initiator request, held until granted.
REQ-007 addr_i  input  32  byte address of the access.
REQ-008 we_i  input  1  1 = write, 0 = read.
REQ-009 be_i  input  4  byte enables, bit n selects wdata[8n+7:8n].
REQ-010 wdata_i  input  32  write data.
REQ-011 gnt_o  output  1  request accepted this cycle.
REQ-012 rvalid_o  output  1  one-cycle response strobe.
REQ-013 rdata_o  output  32  read data, valid while rvalid_o is high.
REQ-014 error_o  output  1  response error, valid while rvalid_o is high.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 gnt_o SHALL be combinational: high only when state is IDLE and req_i is 1.
REQ-017 On a grant the block SHALL capture addr_i, we_i, be_i and wdata_i.
REQ-018 On a grant it SHALL load the latency counter with LATENCY-1.
REQ-019 On a grant it SHALL enter RESP if LATENCY==1, else WAIT.
REQ-020 In WAIT the counter SHALL decrement once per cycle; the block enters RESP on the cycle after the counter reads 1.
REQ-021 rvalid_o SHALL be high for exactly one cycle, in RESP; RESP then always returns to IDLE.
REQ-022 Timing: rvalid_o rises exactly LATENCY cycles after the gnt_o cycle.
REQ-023 Only one transaction SHALL be outstanding; gnt_o stays 0 in WAIT and RESP even when req_i is 1.
REQ-024 Back-to-back: a req_i held through RESP is granted in the following IDLE cycle, giving a minimum of LATENCY+1 cycles between grants.
REQ-025 Decode: word index = (addr - BASE_ADDR) >> 2.
REQ-026 An access is in range if BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH; the compare SHALL use 33-bit arithmetic so no wrap-around occurs at 32'hFFFF_FFFC.
REQ-027 A read SHALL return mem[index] on rdata_o, sampled at RESP.
REQ-028 A write SHALL update only the enabled byte lanes, in the RESP cycle.
REQ-029 For a write, rdata_o SHALL be 32'h0.
REQ-030 be_i == 4'b0000 on a write SHALL be a legal no-op with error_o=0.
REQ-031 addr_i[1:0] != 0 OR address out of range SHALL produce error_o=1 and rdata_o=32'h0, and SHALL perform no write.
REQ-032 A read granted in the cycle after a write's RESP SHALL observe the written data.
REQ-033 Outside RESP, rdata_o and error_o SHALL be 0.

Reset
REQ-034 While reset is asserted, the FSM SHALL be forced to IDLE with the counter at 0 and the captured request registers at 0.
REQ-035 While reset is asserted, gnt_o, rvalid_o, error_o and rdata_o SHALL be 0 during and after reset.
REQ-036 Reset mid-transaction (WAIT or RESP) SHALL abandon it: no write occurs and no rvalid_o is produced.
REQ-037 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-038 The state enum (IDLE/WAIT/RESP) and default BASE_ADDR SHALL live in shared package mem_resp_pkg.
REQ-039 Storage SHALL be one sub-module, be_word_ram: DEPTH x 32 with synchronous byte-enabled write and asynchronous read.
REQ-040 The FSM and the address decode SHALL stay in data_mem_responder.

Verification
REQ-041 The bench SHALL run a reset, then hold req_i=0 for 10 cycles, requiring gnt_o=0 and rvalid_o=0 throughout.
REQ-042 The bench SHALL cover a full-word write: LATENCY=2, write 32'hDEADBEEF to BASE_ADDR+8 with be=4'hF, then read it back; the read SHALL give gnt then rvalid 2 cycles later with rdata=32'hDEADBEEF and error=0.
REQ-043 The bench SHALL cover a partial write: write 32'h11223344 to BASE_ADDR+8 with be=4'b0101; a following read SHALL return 32'hDE22BE44.
REQ-044 The bench SHALL cover errors: a read at BASE_ADDR+2 and a write at BASE_ADDR+4*DEPTH SHALL both give error=1 and rdata=0; a following read at BASE_ADDR+4*DEPTH-4 SHALL show that word unchanged.
REQ-045 The bench SHALL cover back-to-back requests: req_i held high for 3 requests at LATENCY=1 SHALL give grants exactly 2 cycles apart and one rvalid per grant.
REQ-046 The bench SHALL cover reset mid-transaction: assert reset in WAIT of a write to BASE_ADDR+0 (LATENCY=4); there SHALL be no rvalid, and a subsequent read SHALL return the old value.
